// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC step sequencer: state encoding,
// opcode classes and the opcode values the control decode recognises.
package kgp_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALUI,
    CLS_BR,
    CLS_RTYPE,
    CLS_LD,
    CLS_ST,
    CLS_ILL
  } opclass_t;

  localparam logic [5:0] OP_ALUI_LO = 6'b000001;
  localparam logic [5:0] OP_ALUI_HI = 6'b000011;
  localparam logic [5:0] OP_BR_LO   = 6'b000100;
  localparam logic [5:0] OP_BR_HI   = 6'b000110;
  localparam logic [5:0] OP_LINK    = 6'b000110;
  localparam logic [5:0] OP_RTYPE_A = 6'b111100;
  localparam logic [5:0] OP_RTYPE_B = 6'b111101;
  localparam logic [5:0] OP_LOAD    = 6'b111110;
  localparam logic [5:0] OP_STORE   = 6'b111111;

endpackage

// File: rtl/kgp_step_sequencer_if.sv
// Datapath/memory-side signal bundle of the step sequencer.
// master = sequencer, slave = datapath and unified memory port.
interface kgp_step_sequencer_if;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ready;
  logic       ir_write;
  logic       pc_incr;
  logic       pc_write;
  logic       reg_write;
  logic [5:0] opcode;
  logic       branch_taken;

  modport master (
    output mem_req, mem_we, ir_write, pc_incr, pc_write, reg_write,
    input  mem_ready, opcode, branch_taken
  );

  modport slave (
    input  mem_req, mem_we, ir_write, pc_incr, pc_write, reg_write,
    output mem_ready, opcode, branch_taken
  );
endinterface

// File: rtl/kgp_opclass.sv
// Combinational opcode -> instruction class decode, shared with the
// main-control decode.
module kgp_opclass
  import kgp_pkg::*;
(
  input  logic [5:0] opcode,
  output opclass_t   cls
);

  always_comb begin
    cls = CLS_ILL;
    if (opcode >= OP_ALUI_LO && opcode <= OP_ALUI_HI) cls = CLS_ALUI;
    else if (opcode >= OP_BR_LO && opcode <= OP_BR_HI) cls = CLS_BR;
    else if (opcode == OP_RTYPE_A || opcode == OP_RTYPE_B) cls = CLS_RTYPE;
    else if (opcode == OP_LOAD) cls = CLS_LD;
    else if (opcode == OP_STORE) cls = CLS_ST;
  end

endmodule

// File: rtl/kgp_step_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with memory-wait watchdog.
// Define KGP_SEQ_PERF_EN to add the retired-instruction counter port.
//
// state  | meaning
// IDLE   | stopped, waiting for run
// FETCH  | instruction read outstanding
// DECODE | classify opcode (illegal -> TRAP)
// EXEC   | branch resolves here; others pick MEM or WB
// MEM    | load/store access outstanding
// WB     | register-file write
// TRAP   | absorbing error state, left only by reset
module kgp_step_sequencer
  import kgp_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  halt,
  kgp_step_sequencer_if.master  bus,
  output logic [2:0]            state,
  output logic                  busy,
  output logic                  trap
`ifdef KGP_SEQ_PERF_EN
  ,
  output logic [31:0]           retired
`endif
);

  // Wait count that, once incremented, reaches all-ones.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = ~(TIMEOUT_W'(1));

  state_t               state_q, state_d;
  opclass_t             cls_q, cls_dec;
  logic                 link_q;
  logic [TIMEOUT_W-1:0] wdog_q;
  logic                 wdog_expire;
  logic                 boundary;
  logic                 mem_req, mem_we, ir_write, pc_incr, pc_write, reg_write;

  kgp_opclass u_opclass (
    .opcode (bus.opcode),
    .cls    (cls_dec)
  );

  assign wdog_expire = (wdog_q == WDOG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= CLS_ILL;
      link_q  <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q  <= cls_dec;
        link_q <= (bus.opcode == OP_LINK);
      end
      // Any cycle without a stalled request clears it, which covers entry to FETCH/MEM.
      if (mem_req && !bus.mem_ready) wdog_q <= wdog_q + TIMEOUT_W'(1);
      else                           wdog_q <= '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_incr   = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    boundary  = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_incr  = 1'b1;
          state_d  = S_DECODE;
        end else if (wdog_expire) begin
          state_d = S_TRAP;
        end
      end

      S_DECODE: state_d = (cls_dec == CLS_ILL) ? S_TRAP : S_EXEC;

      S_EXEC: begin
        case (cls_q)
          CLS_ALUI, CLS_RTYPE: state_d = S_WB;
          CLS_LD, CLS_ST:      state_d = S_MEM;
          CLS_BR: begin
            pc_write  = bus.branch_taken;
            reg_write = link_q;
            boundary  = 1'b1;
          end
          default:             state_d = S_TRAP;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CLS_ST);
        if (bus.mem_ready) begin
          if (cls_q == CLS_ST) boundary = 1'b1;
          else                 state_d  = S_WB;
        end else if (wdog_expire) begin
          state_d = S_TRAP;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        boundary  = 1'b1;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_TRAP;
    endcase

    if (boundary) state_d = halt ? S_IDLE : S_FETCH;
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.ir_write  = ir_write;
  assign bus.pc_incr   = pc_incr;
  assign bus.pc_write  = pc_write;
  assign bus.reg_write = reg_write;

  assign state = state_q;
  assign busy  = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign trap  = (state_q == S_TRAP);

`ifdef KGP_SEQ_PERF_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        retired_q <= '0;
    else if (boundary) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_kgp_step_sequencer.sv
// Randomized self-checking bench: a per-instruction cycle-trace model built
// from the instruction class table is compared against the DUT every cycle.
module tb_kgp_step_sequencer;

  localparam int TW         = 4;
  localparam int WAIT_LIMIT = (1 << TW) - 1;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd7;
  localparam logic [5:0] REQ = 6'b100000, WE = 6'b010000, IRW = 6'b001000,
                         PCI = 6'b000100, PCW = 6'b000010, RW = 6'b000001;

  logic clk = 1'b0, rst_n = 1'b1, run = 1'b0, halt = 1'b0;
  logic [2:0] state;
  logic busy, trap;
`ifdef KGP_SEQ_PERF_EN
  logic [31:0] retired;
`endif

  kgp_step_sequencer_if bus ();

  kgp_step_sequencer #(.TIMEOUT_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .halt  (halt),
    .bus   (bus),
    .state (state),
    .busy  (busy),
    .trap  (trap)
`ifdef KGP_SEQ_PERF_EN
    ,
    .retired (retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [5:0] stb;
    logic       rdy, run, hlt, bt, bnd;
    logic [5:0] op;
  } rec_t;

  rec_t        q[$];
  int          n_checks = 0, n_fail = 0;
  int unsigned ret_model = 0;
  bit          idle = 1'b1, noise_en = 1'b0, hold_halt = 1'b0;
  logic [5:0]  cur_op = '0;
  logic        cur_bt = 1'b0, cur_halt = 1'b0;
  logic [5:0]  legal[10] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd60, 6'd61, 6'd62, 6'd63};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic nz();
    return noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic void push(input logic [2:0] st, input logic [5:0] stb,
                               input int rdy_mode, input bit bnd);
    rec_t r;
    r.st  = st;
    r.stb = stb;
    r.rdy = (rdy_mode == 2) ? nz() : logic'(rdy_mode == 1);
    r.run = nz();
    r.hlt = bnd ? cur_halt : (hold_halt ? 1'b1 : nz());
    r.bt  = cur_bt;
    r.bnd = bnd;
    r.op  = cur_op;
    q.push_back(r);
  endfunction

  function automatic void push_trap();
    repeat (3) begin
      push(ST_TRAP, 6'd0, 2, 1'b0);
      q[$].run = 1'b1;
    end
  endfunction

  // 0 alu-imm, 1 branch, 2 r-type, 3 load, 4 store, 5 illegal
  function automatic int cls_of(input logic [5:0] op);
    if (op >= 6'd1 && op <= 6'd3) return 0;
    if (op >= 6'd4 && op <= 6'd6) return 1;
    if (op == 6'd60 || op == 6'd61) return 2;
    if (op == 6'd62) return 3;
    if (op == 6'd63) return 4;
    return 5;
  endfunction

  // Pushes n stalled request cycles; returns 1 if the watchdog ends in TRAP.
  function automatic bit wait_phase(input logic [2:0] st, input logic [5:0] stb, input int n);
    int k = (n < WAIT_LIMIT) ? n : WAIT_LIMIT;
    for (int i = 0; i < k; i++) push(st, stb, 0, 1'b0);
    if (n >= WAIT_LIMIT) begin
      push_trap();
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit gen_instr(input logic [5:0] op, input logic bt, input int fw,
                                   input int mw, input logic h);
    int c = cls_of(op);
    cur_op   = op;
    cur_bt   = bt;
    cur_halt = h;
    if (idle) begin
      push(ST_IDLE, 6'd0, 2, 1'b0);
      q[$].run = 1'b1;
      idle = 1'b0;
    end
    if (wait_phase(ST_FETCH, REQ, fw)) return 1'b1;
    push(ST_FETCH, REQ | IRW | PCI, 1, 1'b0);
    if (noise_en)
      foreach (q[i]) if (q[i].st == ST_FETCH) q[i].op = 6'($urandom);
    push(ST_DECODE, 6'd0, 2, 1'b0);
    case (c)
      0, 2: begin
        push(ST_EXEC, 6'd0, 2, 1'b0);
        push(ST_WB, RW, 2, 1'b1);
      end
      1: push(ST_EXEC, (bt ? PCW : 6'd0) | ((op == 6'b000110) ? RW : 6'd0), 2, 1'b1);
      3: begin
        push(ST_EXEC, 6'd0, 2, 1'b0);
        if (wait_phase(ST_MEM, REQ, mw)) return 1'b1;
        push(ST_MEM, REQ, 1, 1'b0);
        push(ST_WB, RW, 2, 1'b1);
      end
      4: begin
        push(ST_EXEC, 6'd0, 2, 1'b0);
        if (wait_phase(ST_MEM, REQ | WE, mw)) return 1'b1;
        push(ST_MEM, REQ | WE, 1, 1'b1);
      end
      default: begin
        push_trap();
        return 1'b1;
      end
    endcase
    idle = h;
    return 1'b0;
  endfunction

  function automatic logic [10:0] obs();
    return {state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_incr,
            bus.pc_write, bus.reg_write, busy, trap};
  endfunction

  task automatic chk_ret();
`ifdef KGP_SEQ_PERF_EN
    check("retired", retired, ret_model);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset", {21'd0, obs()}, 32'd0);
    q.delete();
    idle      = 1'b1;
    ret_model = 0;
    chk_ret();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drives each record after a rising edge and samples 1 ns later.
  task automatic run_queue(input bit cut_in_mem);
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      run              = r.run;
      halt             = r.hlt;
      bus.opcode       = r.op;
      bus.branch_taken = r.bt;
      bus.mem_ready    = r.rdy;
      #1;
      check("trace", {21'd0, obs()},
            {21'd0, r.st, r.stb, logic'(r.st != ST_IDLE && r.st != ST_TRAP), logic'(r.st == ST_TRAP)});
      if (cut_in_mem && r.st == ST_MEM) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_store", {27'd0, state, bus.mem_req, bus.mem_we}, 32'd0);
        q.delete();
        idle      = 1'b1;
        ret_model = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      if (r.bnd) ret_model++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit t;
    bus.mem_ready    = 1'b0;
    bus.opcode       = 6'd0;
    bus.branch_taken = 1'b0;
    #1;
    do_reset();

    repeat (2) begin
      push(ST_IDLE, 6'd0, 2, 1'b0);
      q[$].run = 1'b0;
    end
    run_queue(1'b0);

    t = gen_instr(6'b000001, 1'b0, 0, 0, 1'b0); run_queue(1'b0); chk_ret();
    t = gen_instr(6'b111110, 1'b0, 0, 3, 1'b0); run_queue(1'b0); chk_ret();
    t = gen_instr(6'b000110, 1'b0, 0, 0, 1'b0); run_queue(1'b0); chk_ret();
    t = gen_instr(6'b000101, 1'b1, 2, 0, 1'b0); run_queue(1'b0); chk_ret();

    hold_halt = 1'b1;
    t = gen_instr(6'b111111, 1'b0, 1, 3, 1'b1); run_queue(1'b0); chk_ret();
    hold_halt = 1'b0;
    t = gen_instr(6'b111100, 1'b0, 0, 0, 1'b0); run_queue(1'b0); chk_ret();

    t = gen_instr(6'b001000, 1'b0, 0, 0, 1'b0); run_queue(1'b0);
    check("ill_trapped", {31'd0, t}, 32'd1);
    do_reset();

    t = gen_instr(6'b000001, 1'b0, WAIT_LIMIT, 0, 1'b0); run_queue(1'b0); do_reset();
    t = gen_instr(6'b111110, 1'b0, 0, WAIT_LIMIT, 1'b0); run_queue(1'b0); do_reset();
    t = gen_instr(6'b111111, 1'b0, 0, 4, 1'b0); run_queue(1'b1); chk_ret();

    noise_en = 1'b1;
    repeat (150) begin
      logic [5:0] op;
      int sel = $urandom_range(0, 11);
      op = (sel < 10) ? legal[sel] : 6'($urandom);
      t = gen_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    $urandom_range(0, 3), logic'($urandom_range(0, 5) == 0));
      run_queue(1'b0);
      if (t) do_reset();
      else   chk_ret();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/kgp_step_sequencer.md
# kgp_step_sequencer

Multi-cycle instruction sequencer for KGP-RISC. It steps one instruction at a time through fetch, decode, execute, memory and writeback, driving the enable strobes around the combinational main-control decode. Each step is a handshake with a variable-latency unified memory port. It sits between the top-level core wrapper and the datapath registers (PC, IR, register file, memory interface).

## Interface
- `TIMEOUT_W`, default 8: width of the memory-wait watchdog counter. Timeout fires after 2^TIMEOUT_W − 1 wait cycles.
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  level; leave IDLE and begin fetching
- `halt`  in  1  level; sampled only at instruction boundary
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `branch_taken`  in  1  branch condition from datapath, valid in EXEC
- `mem_ready`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`  out  1  write qualifier for `mem_req`
- `ir_write`  out  1  latch fetched word into IR
- `pc_incr`  out  1  PC ← PC+4
- `pc_write`  out  1  PC ← branch target
- `reg_write`  out  1  register-file write enable
- `state`  out  3  current FSM state encoding
- `busy`  out  1  state ≠ IDLE and ≠ TRAP
- `trap`  out  1  sticky error: illegal opcode or memory timeout
- `retired`  out  32  retired-instruction count. Only with `KGP_SEQ_PERF_EN`.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
- IDLE → FETCH when `run`=1.
- FETCH:
  - `mem_req`=1, `mem_we`=0.
  - On `mem_ready`: pulse `ir_write` and `pc_incr` for one cycle, then go to DECODE.
- DECODE: one cycle. Classify `opcode`:
  - ALU-imm: 000001–000011
  - branch: 000100–000110
  - R-type: 111100, 111101
  - load: 111110
  - store: 111111
  - anything else → TRAP.
- EXEC: one cycle. Next state by class:
  - ALU-imm and R-type → WB.
  - load and store → MEM.
  - Branch: `pc_write`=`branch_taken`. Opcode 000110 (link) also asserts `reg_write` unconditionally in EXEC. Then → boundary.
- MEM:
  - `mem_req`=1; `mem_we`=1 for store only.
  - On `mem_ready`: load → WB, store → boundary.
- WB: `reg_write`=1 for one cycle, then → boundary.
- Boundary (instruction end):
  - `halt`=1 → IDLE.
  - Otherwise → FETCH. `run` is not re-checked.
- TRAP:
  - Absorbing. `trap`=1, all strobes 0.
  - Left only via `rst_n`.
- Watchdog:
  - Counter clears on entry to FETCH or MEM.
  - Increments every cycle `mem_req`=1 and `mem_ready`=0.
  - At all-ones → TRAP next cycle. `mem_req` drops on the TRAP entry cycle.
- All strobes (`mem_req`, `mem_we`, `ir_write`, `pc_incr`, `pc_write`, `reg_write`) are decoded combinationally from registered state, registered class and inputs. They are glitch-free relative to `clk`.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE, `trap`=0, `busy`=0, all strobes 0, watchdog=0, `retired`=0.
- Minimum latency with `mem_ready` same-cycle, from FETCH entry to next FETCH entry:
  - branch: 3 cycles
  - store: 4 cycles
  - ALU / R-type: 4 cycles
  - load: 5 cycles
- Each memory wait cycle adds one cycle.
- `mem_req` asserted with `mem_ready` already high: completes in that cycle. No minimum request width.
- `mem_ready` outside FETCH/MEM: ignored.
- `halt` and `run` both high at a boundary: `halt` wins → IDLE. From IDLE, `run` restarts the next cycle.
- `rst_n` low mid-MEM store: `mem_req`/`mem_we` drop asynchronously. No partial-state retention.
- `retired` increments on the boundary cycle. It wraps 0xFFFFFFFF → 0.

## Configuration
- `KGP_SEQ_PERF_EN` defined:
  - `retired` counter is instantiated and exported.
- Not defined:
  - `retired` port is absent, no counter flops.
  - FSM behaviour is identical.

## Structure
- Shared package `kgp_pkg` holds:
  - state encoding constants
  - opcode class enum {CLS_ALUI, CLS_BR, CLS_RTYPE, CLS_LD, CLS_ST, CLS_ILL}
  - opcode constants, including the 000110 link opcode
- One sub-module, `kgp_opclass`: combinational 6-bit opcode → class decode. It is reusable by the main control decode.
- The watchdog and the optional perf counter live inline.

## Test plan
- Reset, then `run`=1, opcode 000001, `mem_ready` tied 1 → FETCH, DECODE, EXEC, WB. `reg_write` high exactly in cycle 4. Back in FETCH at cycle 5.
- Load 111110 with `mem_ready` delayed 3 cycles in MEM:
  - `mem_req` held 4 cycles, `mem_we`=0.
  - WB follows.
  - `retired` +1 with macro defined.
- Opcode 000110, `branch_taken`=0 → `reg_write`=1 and `pc_write`=0 in EXEC. Next FETCH follows after 3 cycles.
- Opcode 001000 → TRAP after DECODE. `trap`=1, `busy`=0, stays there despite `run`. `rst_n` pulse → IDLE.
- `mem_ready` held 0 in FETCH with `TIMEOUT_W`=4 → TRAP after 15 wait cycles; `mem_req` low afterward.
- `halt`=1 during a store's MEM wait → store completes with `mem_we`=1, then IDLE, not FETCH.
